// File: rtl/fir_seq_ctrl.sv
// FIR pass sequencer: walks the coefficient ROM alongside a queue burst,
// multiply-accumulates both channels and emits saturated 16-bit results.
module fir_seq_ctrl #(
    parameter int TAPS   = 1021,
    parameter int ADDR_W = 10,
    parameter int SHIFT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sequencing,
    input  logic [15:0]       lft_smpl,
    input  logic [15:0]       rght_smpl,
    input  logic [15:0]       coeff,
    output logic [ADDR_W-1:0] coeff_addr,
    output logic [15:0]       lft_out,
    output logic [15:0]       rght_out,
    output logic              valid,
    output logic              abort
);

    localparam int ACC_W = 32 + $clog2(TAPS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-32768);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         tap_q, tap_d;
    logic                      mac_en_q, issue, clr;
    logic signed [ACC_W-1:0]   acc_l_q, acc_r_q, sum_l, sum_r;
    logic signed [31:0]        prod_l, prod_r;
    logic [15:0]               lft_q, lft_d, rght_q, rght_d;
    logic                      valid_q, valid_d, abort_q, abort_d;

    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> SHIFT;
        if (s > MAXV)      return 16'h7fff;
        else if (s < MINV) return 16'h8000;
        else               return s[15:0];
    endfunction

    always_comb begin
        prod_l = 32'($signed(lft_smpl)) * 32'($signed(coeff));
        prod_r = 32'($signed(rght_smpl)) * 32'($signed(coeff));
        sum_l  = mac_en_q ? acc_l_q + ACC_W'(prod_l) : acc_l_q;
        sum_r  = mac_en_q ? acc_r_q + ACC_W'(prod_r) : acc_r_q;
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        issue   = 1'b0;
        clr     = 1'b0;
        abort_d = 1'b0;
        valid_d = 1'b0;
        lft_d   = lft_q;
        rght_d  = rght_q;
        unique case (state_q)
            IDLE: begin
                tap_d = '0;
                if (sequencing) begin
                    issue   = 1'b1;
                    clr     = 1'b1;
                    tap_d   = ADDR_W'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sequencing) begin
                    issue = 1'b1;
                    if (tap_q == LAST) begin
                        tap_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        tap_d = tap_q + ADDR_W'(1);
                    end
                end else begin
                    abort_d = 1'b1;
                    tap_d   = '0;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // last product still in flight: fold it in while loading
                tap_d   = '0;
                lft_d   = sat16(sum_l);
                rght_d  = sat16(sum_r);
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                tap_d = '0;
                if (!sequencing) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            mac_en_q <= 1'b0;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            lft_q    <= '0;
            rght_q   <= '0;
            valid_q  <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            mac_en_q <= issue;
            acc_l_q  <= clr ? '0 : sum_l;
            acc_r_q  <= clr ? '0 : sum_r;
            lft_q    <= lft_d;
            rght_q   <= rght_d;
            valid_q  <= valid_d;
            abort_q  <= abort_d;
        end
    end

    assign coeff_addr = tap_q;
    assign lft_out    = lft_q;
    assign rght_out   = rght_q;
    assign valid      = valid_q;
    assign abort      = abort_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: models queue RAM and coefficient ROM, compares
// each pass against a direct dot-product reference.
module tb_fir_seq_ctrl;

    localparam int TAPS   = 1021;
    localparam int ADDR_W = 10;
    localparam int SHIFT  = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sequencing = 1'b0;
    logic [15:0]       lft_smpl = '0;
    logic [15:0]       rght_smpl = '0;
    logic [15:0]       coeff = '0;
    logic [ADDR_W-1:0] coeff_addr;
    logic [15:0]       lft_out, rght_out;
    logic              valid, abort;

    fir_seq_ctrl #(.TAPS(TAPS), .ADDR_W(ADDR_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .sequencing(sequencing),
        .lft_smpl(lft_smpl), .rght_smpl(rght_smpl), .coeff(coeff),
        .coeff_addr(coeff_addr), .lft_out(lft_out), .rght_out(rght_out),
        .valid(valid), .abort(abort)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic signed [15:0] L [TAPS];
    logic signed [15:0] R [TAPS];
    logic signed [15:0] rom [1 << ADDR_W];

    int ncyc = 0, k = 0, prev_rd = -1;
    int nval, nab, nboth, vcyc, acyc, lcyc, aerr;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [15:0] obs_l, obs_r;
    int exp_l = 0, exp_r = 0;

    task automatic chk(input string tag, input longint o, input longint e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Reference: plain dot product, arithmetic shift, clamp.
    function automatic int model(input bit right);
        longint acc = 0;
        longint s;
        for (int i = 0; i < TAPS; i++)
            acc += longint'(right ? R[i] : L[i]) * longint'(rom[i]);
        s = acc >>> SHIFT;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < TAPS; i++) begin
            L[i] = 16'($urandom);
            R[i] = 16'($urandom);
        end
        for (int i = 0; i < (1 << ADDR_W); i++)
            rom[i] = 16'(int'($urandom_range(0, 511)) - 256);
    endtask

    task automatic cyc(input logic s);
        @(negedge clk);
        ncyc++;
        if (valid) begin
            nval++;
            vcyc  = ncyc;
            obs_l = lft_out;
            obs_r = rght_out;
        end
        if (abort) begin
            nab++;
            acyc = ncyc;
        end
        if (valid && abort) nboth++;
        coeff = rom[prev_addr];
        if (prev_rd >= 0 && prev_rd < TAPS) begin
            lft_smpl  = L[prev_rd];
            rght_smpl = R[prev_rd];
        end else begin
            lft_smpl  = 16'($urandom);
            rght_smpl = 16'($urandom);
        end
        prev_addr  = coeff_addr;
        sequencing = s;
        if (s) begin
            if (k < TAPS && int'(coeff_addr) != k) aerr++;
            if (k == TAPS - 1) lcyc = ncyc;
            prev_rd = k;
            k++;
        end else begin
            prev_rd = -1;
        end
    endtask

    task automatic burst(input string tag, input int nhigh, input int gap);
        int start;
        k = 0; nval = 0; nab = 0; nboth = 0; aerr = 0;
        vcyc = -1; acyc = -1; lcyc = -1;
        start = ncyc + 1;
        repeat (nhigh) cyc(1'b1);
        repeat (gap) cyc(1'b0);
        chk({tag, "_both"}, nboth, 0);
        chk({tag, "_addr"}, aerr, 0);
        if (nhigh >= TAPS) begin
            exp_l = model(1'b0);
            exp_r = model(1'b1);
            chk({tag, "_nval"}, nval, 1);
            chk({tag, "_nabort"}, nab, 0);
            chk({tag, "_lat"}, vcyc, lcyc + 2);
            chk({tag, "_lft"}, longint'($signed(obs_l)), exp_l);
            chk({tag, "_rght"}, longint'($signed(obs_r)), exp_r);
        end else if (nhigh == 0) begin
            chk({tag, "_nval"}, nval, 0);
            chk({tag, "_nabort"}, nab, 0);
        end else begin
            chk({tag, "_nval"}, nval, 0);
            chk({tag, "_nabort"}, nab, 1);
            chk({tag, "_abcyc"}, acyc, start + nhigh + 1);
            chk({tag, "_lft_hold"}, longint'($signed(lft_out)), exp_l);
            chk({tag, "_rght_hold"}, longint'($signed(rght_out)), exp_r);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;
        for (int i = 0; i < TAPS; i++) begin
            L[i] = '0;
            R[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_addr", coeff_addr, 0);
        chk("rst_lft", lft_out, 0);
        chk("rst_rght", rght_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_abort", abort, 0);
        rst_n = 1'b1;
        repeat (2) cyc(1'b0);

        L[3] = 16'sd16384;
        R[3] = -16'sd16384;
        rom[3] = 16'sh7fff;
        burst("impulse", TAPS, 3);
        chk("impulse_lft_lit", exp_l, 16383);
        chk("impulse_rght_lit", exp_r, -16384);

        for (int i = 0; i < TAPS; i++) begin
            L[i] = 16'sd1000;
            R[i] = 16'sd1000;
            rom[i] = 16'sd32;
        end
        burst("dc", TAPS, 3);
        chk("dc_lit", exp_l, 997);

        for (int i = 0; i < TAPS; i++) begin
            L[i] = 16'sh7fff;
            R[i] = 16'sh8000;
            rom[i] = 16'sh7fff;
        end
        burst("sat", TAPS, 3);
        chk("sat_lit_l", exp_l, 32767);
        chk("sat_lit_r", exp_r, -32768);

        fill_rand();
        burst("early600", 600, 3);
        fill_rand();
        burst("rand1", TAPS, 3);

        fill_rand();
        burst("overlong", TAPS + 1, 1);
        fill_rand();
        burst("b2b", TAPS, 3);

        fill_rand();
        k = 0;
        repeat (500) cyc(1'b1);
        rst_n = 1'b0;
        sequencing = 1'b0;
        #1;
        chk("midrst_addr", coeff_addr, 0);
        chk("midrst_lft", lft_out, 0);
        chk("midrst_rght", rght_out, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_abort", abort, 0);
        prev_rd = -1;
        exp_l = 0;
        exp_r = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        burst("post_rst", 0, 5);
        fill_rand();
        burst("rand2", TAPS, 3);

        for (int n = 0; n < 2; n++) begin
            fill_rand();
            burst("early_rand", int'($urandom_range(1, TAPS - 1)), 3);
            burst("rand_full", TAPS, 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
